// File: rtl/iob_ram_tdp_bist_pkg.sv
// Shared types for the iob_ram_tdp BIST initiator: FSM state encoding and failure phase codes.
// RD_X is only reachable when IOB_RAM_TDP_BIST_CROSS_EN is defined.
package iob_ram_tdp_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_A = 3'd1,
        ST_RD_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_RD_B = 3'd4,
        ST_RD_X = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_A    = 2'd1;
    localparam logic [1:0] PH_B    = 2'd2;
    localparam logic [1:0] PH_X    = 2'd3;

endpackage

// File: rtl/iob_ram_tdp_bist_chk.sv
// One-cycle compare stage: captures expected word, phase and address of an issued read,
// then checks the RAM output on the following cycle and strobes o_mis on a difference.
module iob_ram_tdp_bist_chk
    import iob_ram_tdp_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              i_vld,
    input  logic [1:0]        i_phase,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_dA,
    input  logic [DATA_W-1:0] i_dB,
    output logic              o_mis,
    output logic [1:0]        o_phase,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_vld;
    logic [1:0]        r_phase;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_exp;
    logic [DATA_W-1:0] w_rd;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_vld   <= 1'b0;
            r_phase <= PH_NONE;
            r_addr  <= '0;
            r_exp   <= '0;
        end else begin
            r_vld   <= i_vld;
            r_phase <= i_phase;
            r_addr  <= i_addr;
            r_exp   <= i_exp;
        end
    end

    // Only the B phase reads through port B; A and cross phases read port A.
    assign w_rd    = (r_phase == PH_B) ? i_dB : i_dA;
    assign o_mis   = r_vld && (w_rd != r_exp);
    assign o_phase = r_phase;
    assign o_addr  = r_addr;
    assign o_data  = w_rd;

endmodule

// File: rtl/iob_ram_tdp_bist.sv
// BIST initiator for iob_ram_tdp: write/read-back of an incremental pattern on port A, then port B.
// Define IOB_RAM_TDP_BIST_CROSS_EN to add RD_X (port A re-read of the port B pattern).
module iob_ram_tdp_bist
    import iob_ram_tdp_bist_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int SEQ_A_INI = 32,
    parameter int SEQ_B_INI = 64
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [1:0]        fail_phase_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic              enA_o,
    output logic              weA_o,
    output logic [ADDR_W-1:0] addrA_o,
    output logic [DATA_W-1:0] dA_o,
    input  logic [DATA_W-1:0] dA_i,
    output logic              enB_o,
    output logic              weB_o,
    output logic [ADDR_W-1:0] addrB_o,
    output logic [DATA_W-1:0] dB_o,
    input  logic [DATA_W-1:0] dB_i
);

    localparam logic [DATA_W-1:0] SEQ_A = DATA_W'(SEQ_A_INI);
    localparam logic [DATA_W-1:0] SEQ_B = DATA_W'(SEQ_B_INI);
    localparam logic [ADDR_W:0]   LAST  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   DRAIN = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W:0] i, input logic [DATA_W-1:0] base);
        return base + DATA_W'(i);
    endfunction

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_busy, r_done, r_pass;
    logic [1:0]        r_fail_phase;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic              r_enA, r_weA, r_enB, r_weB;
    logic [DATA_W-1:0] r_wdata;

    logic              w_rd_vld;
    logic [1:0]        w_phase;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;
    logic [1:0]        w_mis_phase;
    logic [ADDR_W-1:0] w_mis_addr;
    logic [DATA_W-1:0] w_mis_data;

    assign w_rd_vld = (r_enA && !r_weA) || (r_enB && !r_weB);
    assign w_exp    = (r_state == ST_RD_A) ? f_pat(r_cnt, SEQ_A) : f_pat(r_cnt, SEQ_B);

    always_comb begin
        w_phase = PH_NONE;
        case (r_state)
            ST_RD_A: w_phase = PH_A;
            ST_RD_B: w_phase = PH_B;
            ST_RD_X: w_phase = PH_X;
            default: w_phase = PH_NONE;
        endcase
    end

    iob_ram_tdp_bist_chk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .i_vld    (w_rd_vld),
        .i_phase  (w_phase),
        .i_addr   (r_cnt[ADDR_W-1:0]),
        .i_exp    (w_exp),
        .i_dA     (dA_i),
        .i_dB     (dB_i),
        .o_mis    (w_mis),
        .o_phase  (w_mis_phase),
        .o_addr   (w_mis_addr),
        .o_data   (w_mis_data)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_phase <= PH_NONE;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_enA        <= 1'b0;
            r_weA        <= 1'b0;
            r_enB        <= 1'b0;
            r_weB        <= 1'b0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_state      <= ST_WR_A;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail_phase <= PH_NONE;
                        r_fail_addr  <= '0;
                        r_fail_data  <= '0;
                        r_enA        <= 1'b1;
                        r_weA        <= 1'b1;
                        r_wdata      <= SEQ_A;
                    end
                end
                ST_WR_A, ST_WR_B: begin
                    if (r_cnt == LAST) begin
                        r_state <= (r_state == ST_WR_A) ? ST_RD_A : ST_RD_B;
                        r_cnt   <= '0;
                        r_weA   <= 1'b0;
                        r_weB   <= 1'b0;
                        r_wdata <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_wdata <= f_pat(r_cnt + 1'b1, (r_state == ST_WR_A) ? SEQ_A : SEQ_B);
                    end
                end
                ST_RD_A, ST_RD_B, ST_RD_X: begin
                    // A mismatch (including one seen on the drain cycle) ends the run immediately.
                    if (w_mis) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_fail_phase <= w_mis_phase;
                        r_fail_addr  <= w_mis_addr;
                        r_fail_data  <= w_mis_data;
                        r_enA        <= 1'b0;
                        r_weA        <= 1'b0;
                        r_enB        <= 1'b0;
                        r_weB        <= 1'b0;
                    end else if (r_cnt == LAST) begin
                        r_cnt <= DRAIN;
                        r_enA <= 1'b0;
                        r_enB <= 1'b0;
                    end else if (r_cnt == DRAIN) begin
                        r_cnt <= '0;
                        if (r_state == ST_RD_A) begin
                            r_state <= ST_WR_B;
                            r_enB   <= 1'b1;
                            r_weB   <= 1'b1;
                            r_wdata <= SEQ_B;
`ifdef IOB_RAM_TDP_BIST_CROSS_EN
                        end else if (r_state == ST_RD_B) begin
                            r_state <= ST_RD_X;
                            r_enA   <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign fail_phase_o = r_fail_phase;
    assign fail_addr_o  = r_fail_addr;
    assign fail_data_o  = r_fail_data;
    assign enA_o        = r_enA;
    assign weA_o        = r_weA;
    assign addrA_o      = r_cnt[ADDR_W-1:0];
    assign dA_o         = r_wdata;
    assign enB_o        = r_enB;
    assign weB_o        = r_weB;
    assign addrB_o      = r_cnt[ADDR_W-1:0];
    assign dB_o         = r_wdata;

endmodule

// File: tb/tb_iob_ram_tdp_bist.sv
// Bench for iob_ram_tdp_bist with a behavioural TDP RAM carrying per-port read-fault injection.
// Expected run outcomes are queued at start and popped when done_o is reached.
module tb_iob_ram_tdp_bist;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef IOB_RAM_TDP_BIST_CROSS_EN
    localparam int CLEAN_LAT = 5 * N + 3;
`else
    localparam int CLEAN_LAT = 4 * N + 2;
`endif

    typedef struct {
        logic [14:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic          clk_i = 1'b0;
    logic          arst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, pass_o;
    logic [1:0]    fail_phase_o;
    logic [AW-1:0] fail_addr_o;
    logic [DW-1:0] fail_data_o;
    logic          enA_o, weA_o, enB_o, weB_o;
    logic [AW-1:0] addrA_o, addrB_o;
    logic [DW-1:0] dA_o, dB_o;
    logic [DW-1:0] dA_i = '0;
    logic [DW-1:0] dB_i = '0;

    logic [DW-1:0] mem [N];
    logic          b_wr_seen = 1'b0;
    logic          weB_seen  = 1'b0;
    logic          collide   = 1'b0;
    logic          fa_en = 1'b0, fa_after_b = 1'b0, fb_en = 1'b0;
    logic [AW-1:0] fa_addr = '0, fb_addr = '0;

    always #5 clk_i = ~clk_i;

    iob_ram_tdp_bist #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .SEQ_A_INI (32),
        .SEQ_B_INI (64)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .fail_phase_o (fail_phase_o),
        .fail_addr_o  (fail_addr_o),
        .fail_data_o  (fail_data_o),
        .enA_o        (enA_o),
        .weA_o        (weA_o),
        .addrA_o      (addrA_o),
        .dA_o         (dA_o),
        .dA_i         (dA_i),
        .enB_o        (enB_o),
        .weB_o        (weB_o),
        .addrB_o      (addrB_o),
        .dB_o         (dB_o),
        .dB_i         (dB_i)
    );

    // Shared-array TDP RAM; faults clear bit 0 of the read word at one address.
    always @(posedge clk_i) begin
        if (start_i && !busy_o) begin
            b_wr_seen <= 1'b0;
            weB_seen  <= 1'b0;
            collide   <= 1'b0;
        end else begin
            if (enB_o && weB_o) begin
                b_wr_seen <= 1'b1;
                weB_seen  <= 1'b1;
            end
            if (enA_o && enB_o) collide <= 1'b1;
        end
        if (enA_o) begin
            if (weA_o) mem[addrA_o] <= dA_o;
            else if (fa_en && addrA_o == fa_addr && (!fa_after_b || b_wr_seen)) dA_i <= mem[addrA_o] & 8'hFE;
            else dA_i <= mem[addrA_o];
        end
        if (enB_o) begin
            if (weB_o) mem[addrB_o] <= dB_o;
            else if (fb_en && addrB_o == fb_addr) dB_i <= mem[addrB_o] & 8'hFE;
            else dB_i <= mem[addrB_o];
        end
    end

    function automatic logic [14:0] pack_res(input logic p, input logic [1:0] ph, input logic [3:0] a, input logic [7:0] d);
        return {p, ph, a, d};
    endfunction

    // Pulses start, optionally re-pulses it at cycle extra_at, waits (bounded) for done_o.
    task automatic do_run(input int extra_at, output int lat, output logic [4:0] st0);
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        st0 = {busy_o, done_o, pass_o, fail_phase_o};
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk_i); #1;
            start_i = (c == extra_at);
            if (done_o) begin
                lat = c;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [52:0] obs;
        #2;
        obs = {busy_o, done_o, pass_o, fail_phase_o, fail_addr_o, fail_data_o, enA_o, weA_o, addrA_o, dA_o,
               enB_o, weB_o, addrB_o, dB_o};
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
        @(negedge clk_i); arst_n_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        obs = {busy_o, done_o, pass_o, fail_phase_o, fail_addr_o, fail_data_o, enA_o, weA_o, addrA_o, dA_o,
               enB_o, weB_o, addrB_o, dB_o};
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", obs); end
    endtask

    task automatic test_clean();
        exp_t e;
        int lat;
        logic [4:0] st0;
        logic [7:0] want;
        sb.push_back('{res: pack_res(1'b1, 2'd0, 4'd0, 8'd0), lat: CLEAN_LAT});
        do_run(-1, lat, st0);
        e = sb.pop_front();
        n_checks++;
        if (st0 !== 5'b10000) begin n_fail++; $display("FAIL clean_entry: got %b want 10000", st0); end
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL clean_latency: got %0d want %0d", lat, e.lat); end
        n_checks++;
        if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
            begin n_fail++; $display("FAIL clean_status: got %h want %h", {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
        for (int i = 0; i < N; i++) begin
            want = 8'(64 + i);
            n_checks++;
            if (mem[i] !== want) begin n_fail++; $display("FAIL ram_content[%0d]: got %h want %h", i, mem[i], want); end
        end
        n_checks++;
        if (collide !== 1'b0) begin n_fail++; $display("FAIL port_collision: got %b want 0", collide); end
    endtask

    task automatic test_port_a_fault();
        exp_t e;
        int lat;
        logic [4:0] st0;
        fa_en = 1'b1; fa_addr = 4'd5; fa_after_b = 1'b0;
        sb.push_back('{res: pack_res(1'b0, 2'd1, 4'd5, 8'h24), lat: 23});
        do_run(-1, lat, st0);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL a_fault_latency: got %0d want %0d", lat, e.lat); end
        n_checks++;
        if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
            begin n_fail++; $display("FAIL a_fault_status: got %h want %h", {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
        n_checks++;
        if (weB_seen !== 1'b0) begin n_fail++; $display("FAIL a_fault_weB: got %b want 0", weB_seen); end
        fa_en = 1'b0;
    endtask

    task automatic test_port_b_fault();
        exp_t e;
        int lat;
        logic [4:0] st0;
        fb_en = 1'b1; fb_addr = 4'd15;
        sb.push_back('{res: pack_res(1'b0, 2'd2, 4'd15, 8'h4E), lat: 66});
        do_run(-1, lat, st0);
        e = sb.pop_front();
        n_checks++;
        if (st0 !== 5'b10000) begin n_fail++; $display("FAIL b_fault_entry_cleared: got %b want 10000", st0); end
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL b_fault_latency: got %0d want %0d", lat, e.lat); end
        n_checks++;
        if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
            begin n_fail++; $display("FAIL b_fault_status: got %h want %h", {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
        fb_en = 1'b0;
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int lat;
        logic [4:0] st0;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{res: pack_res(1'b1, 2'd0, 4'd0, 8'd0), lat: CLEAN_LAT});
            do_run((r == 0) ? 10 : -1, lat, st0);
            e = sb.pop_front();
            n_checks++;
            if (st0 !== 5'b10000) begin n_fail++; $display("FAIL restart_entry[%0d]: got %b want 10000", r, st0); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL restart_latency[%0d]: got %0d want %0d", r, lat, e.lat); end
            n_checks++;
            if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
                begin n_fail++; $display("FAIL restart_status[%0d]: got %h want %h", r, {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int lat;
        logic [4:0] st0;
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #2;
        n_checks++;
        if ({enA_o, weA_o, busy_o} !== 3'b101) begin n_fail++; $display("FAIL pre_reset_rd_a: got %b want 101", {enA_o, weA_o, busy_o}); end
        arst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({enA_o, weA_o, enB_o, weB_o, busy_o, done_o} !== 6'b0)
            begin n_fail++; $display("FAIL async_drop: got %b want 000000", {enA_o, weA_o, enB_o, weB_o, busy_o, done_o}); end
        @(negedge clk_i); arst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({busy_o, done_o, pass_o, fail_phase_o, enA_o, enB_o} !== 7'b0)
            begin n_fail++; $display("FAIL post_reset_idle: got %b want 0000000", {busy_o, done_o, pass_o, fail_phase_o, enA_o, enB_o}); end
        sb.push_back('{res: pack_res(1'b1, 2'd0, 4'd0, 8'd0), lat: CLEAN_LAT});
        do_run(-1, lat, st0);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, e.lat); end
        n_checks++;
        if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
            begin n_fail++; $display("FAIL post_reset_status: got %h want %h", {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
    endtask

`ifdef IOB_RAM_TDP_BIST_CROSS_EN
    task automatic test_cross_fault();
        exp_t e;
        int lat;
        logic [4:0] st0;
        fa_en = 1'b1; fa_addr = 4'd3; fa_after_b = 1'b1;
        sb.push_back('{res: pack_res(1'b0, 2'd3, 4'd3, 8'h42), lat: 71});
        do_run(-1, lat, st0);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL cross_fault_latency: got %0d want %0d", lat, e.lat); end
        n_checks++;
        if ({pass_o, fail_phase_o, fail_addr_o, fail_data_o} !== e.res)
            begin n_fail++; $display("FAIL cross_fault_status: got %h want %h", {pass_o, fail_phase_o, fail_addr_o, fail_data_o}, e.res); end
        fa_en = 1'b0; fa_after_b = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_port_a_fault();
        test_port_b_fault();
        test_start_ignored();
        test_async_reset();
`ifdef IOB_RAM_TDP_BIST_CROSS_EN
        test_cross_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
